seven_seg_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of N common-anode seven-segment digits sharing one 8-bit segment bus. Scans the digits round-robin, decodes each 4-bit hex nibble to the team's active-low glyph encoding, and adds several features: a guard (ghost-suppression) interval, per-digit enable, decimal points, leading-zero blanking and tear-free frame-synchronous loading. It sits between the value-producing logic and the board pins, replacing the single-digit decoder.

---
 rtl/seven_seg_scan_driver.sv | 204 ++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//
// Time-multiplexed driver for N common-anode seven-segment digits on one
// shared 8-bit active-low segment bus. Digits are scanned round-robin; each
// slot starts with GUARD all-dark cycles to suppress ghosting. A shadow
// register holds the displayed snapshot and only changes at a frame
// boundary, so one frame never mixes two loaded values.
//
// Ports:
//   CLK       clock, all state on rising edge
//   RST_N     synchronous reset, active low
//   D         hex nibbles, digit i = D[4i+3:4i] (digit 0 least significant)
//   DP        decimal point request per digit (1 = lit)
//   EN        digit enable (0 = digit dark for its whole slot)
//   BLANK_LZ  leading-zero blanking enable
//   LOAD      one-cycle strobe capturing D/DP/EN/BLANK_LZ
//   SEG       active-low segments {g,f,e,d,c,b,a,dp}
//   AN        digit select, active level set by AN_ACTIVE_LOW
//   FRAME     one-cycle pulse when outputs belong to slot 0, cycle 0
module seven_seg_scan_driver #(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned CLK_DIV       = 1000,
  parameter int unsigned GUARD         = 4,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*N_DIGITS-1:0] D,
  input  logic [N_DIGITS-1:0]   DP,
  input  logic [N_DIGITS-1:0]   EN,
  input  logic                  BLANK_LZ,
  input  logic                  LOAD,
  output logic [7:0]            SEG,
  output logic [N_DIGITS-1:0]   AN,
  output logic                  FRAME
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CW-1:0]       CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]       GUARD_CNT = CW'(GUARD);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  // Active-low a..g pattern, returned as SEG[7:1] = {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Scan counters
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;

  // Displayed snapshot
  logic [4*N_DIGITS-1:0] sh_val_q;
  logic [N_DIGITS-1:0]   sh_dp_q;
  logic [N_DIGITS-1:0]   sh_en_q;
  logic                  sh_blz_q;

  // Load waiting for the next frame boundary
  logic [4*N_DIGITS-1:0] pd_val_q;
  logic [N_DIGITS-1:0]   pd_dp_q;
  logic [N_DIGITS-1:0]   pd_en_q;
  logic                  pd_blz_q;
  logic                  pend_valid_q;

  logic [7:0]          seg_q;
  logic [N_DIGITS-1:0] an_q;
  logic                frame_q;

  logic slot_end;
  logic frame_end;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Leading-zero run walks down from the top digit; a zero nibble with its
  // DP lit ends the run, and digit 0 is never part of it.
  logic [N_DIGITS-1:0] lz_blank;

  always_comb begin
    logic run;
    lz_blank = '0;
    run      = sh_blz_q;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      run         = run & (sh_val_q[4*i +: 4] == 4'h0) & ~sh_dp_q[i];
      lz_blank[i] = run;
    end
  end

  // Fields of the digit selected by idx, plus its one-hot anode.
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_en;
  logic                cur_lz;
  logic [N_DIGITS-1:0] cur_onehot;

  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_lz     = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib       = sh_val_q[4*i +: 4];
        cur_dp        = sh_dp_q[i];
        cur_en        = sh_en_q[i];
        cur_lz        = lz_blank[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  // Output function of the current cnt/idx/shadow, registered below.
  logic [7:0]          seg_n;
  logic [N_DIGITS-1:0] an_n;
  logic                frame_n;

  always_comb begin
    seg_n   = 8'hFF;
    an_n    = AN_OFF;
    frame_n = (cnt_q == '0) && (idx_q == '0);
    if ((cnt_q >= GUARD_CNT) && cur_en) begin
      seg_n = {(cur_lz ? 7'h7F : glyph(cur_nib)), ~cur_dp};
      an_n  = AN_ACTIVE_LOW ? ~cur_onehot : cur_onehot;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      sh_blz_q     <= 1'b0;
      pd_val_q     <= '0;
      pd_dp_q      <= '0;
      pd_en_q      <= '0;
      pd_blz_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      seg_q        <= 8'hFF;
      an_q         <= AN_OFF;
      frame_q      <= 1'b0;
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      if (frame_end) begin
        // A LOAD landing on the boundary itself bypasses pending.
        if (LOAD) begin
          sh_val_q <= D;
          sh_dp_q  <= DP;
          sh_en_q  <= EN;
          sh_blz_q <= BLANK_LZ;
        end else if (pend_valid_q) begin
          sh_val_q <= pd_val_q;
          sh_dp_q  <= pd_dp_q;
          sh_en_q  <= pd_en_q;
          sh_blz_q <= pd_blz_q;
        end
        pend_valid_q <= 1'b0;
      end else if (LOAD) begin
        pd_val_q     <= D;
        pd_dp_q      <= DP;
        pd_en_q      <= EN;
        pd_blz_q     <= BLANK_LZ;
        pend_valid_q <= 1'b1;
      end

      seg_q   <= seg_n;
      an_q    <= an_n;
      frame_q <= frame_n;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int CD = 8;
  localparam int G  = 2;
  localparam int FL = ND * CD;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] D = '0;
  logic [3:0]  DP = '0;
  logic [3:0]  EN = '0;
  logic        BLANK_LZ = 1'b0;
  logic        LOAD = 1'b0;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic        FRAME;

  seven_seg_scan_driver #(
    .N_DIGITS     (ND),
    .CLK_DIV      (CD),
    .GUARD        (G),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .D       (D),
    .DP      (DP),
    .EN      (EN),
    .BLANK_LZ(BLANK_LZ),
    .LOAD    (LOAD),
    .SEG     (SEG),
    .AN      (AN),
    .FRAME   (FRAME)
  );

  always #5 CLK = ~CLK;

  // Expected content of one whole frame: SEG per digit {d3,d2,d1,d0} and enables.
  typedef struct {
    int          frame;
    logic [31:0] segs;
    logic [3:0]  en;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_cnt = 0;
  int   pos = 0;

  // Hand-computed SEG words
  localparam logic [31:0] S_1A3F = {8'b11110011, 8'b00010001, 8'b01100001, 8'b00011101};
  localparam logic [31:0] S_LZ5  = {8'hFF, 8'hFF, 8'hFF, 8'b00100101};
  localparam logic [31:0] S_LZDP = {8'hFF, 8'hFF, 8'b10000000, 8'b00100101};
  localparam logic [31:0] S_BCDE = {8'b00000111, 8'b10001100, 8'b01000011, 8'b00001100};
  localparam logic [31:0] S_9604 = {8'b00100001, 8'b00000101, 8'b10000001, 8'b00110011};
  localparam logic [31:0] S_1234 = {8'b11110011, 8'b01001001, 8'b01100001, 8'b00110011};

  // Frame index: value seen at the negedge carrying the FRAME pulse.
  always @(posedge CLK) if (FRAME === 1'b1) frame_cnt <= frame_cnt + 1;

  logic [7:0] seg_s[FL];
  logic [3:0] an_s[FL];
  logic       fr_s[FL];

  task automatic check_frame(input exp_t e);
    for (int s = 0; s < ND; s++) begin
      logic [7:0] es, bes;
      logic [3:0] ea, bea;
      logic       ef, bef;
      int         bad;
      bad = -1;
      bes = '0; bea = '0; bef = 1'b0;
      for (int c = 0; c < CD; c++) begin
        int j;
        j  = s * CD + c;
        es = 8'hFF;
        ea = 4'hF;
        if (c >= G && e.en[s]) begin
          es = e.segs[8*s +: 8];
          ea = ~(4'b0001 << s);
        end
        ef = (j == 0);
        if (bad < 0 && (seg_s[j] !== es || an_s[j] !== ea || fr_s[j] !== ef)) begin
          bad = j; bes = es; bea = ea; bef = ef;
        end
      end
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL frame%0d_slot%0d cycle %0d: got SEG=%b AN=%b FRAME=%b, expected SEG=%b AN=%b FRAME=%b",
                 e.frame, s, bad % CD, seg_s[bad], an_s[bad], fr_s[bad], bes, bea, bef);
      end
    end
  endtask

  // Monitor: record each complete frame, then score every expectation for it.
  initial begin : monitor
    int   tag;
    bit   ok;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (FRAME === 1'b1 && RST_N === 1'b1) begin
        tag = frame_cnt;
        ok  = 1'b1;
        seg_s[0] = SEG; an_s[0] = AN; fr_s[0] = FRAME;
        for (int j = 1; j < FL; j++) begin
          @(negedge CLK);
          if (RST_N !== 1'b1) begin
            ok = 1'b0;
            break;
          end
          seg_s[j] = SEG; an_s[j] = AN; fr_s[j] = FRAME;
        end
        if (ok) begin
          while (sb.size() > 0 && sb[0].frame < tag) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL frame%0d_missed: got no complete frame, expected one", e.frame);
          end
          while (sb.size() > 0 && sb[0].frame == tag) begin
            e = sb.pop_front();
            check_frame(e);
          end
        end
      end
    end
  end

  task automatic push(input int f, input logic [31:0] segs, input logic [3:0] en);
    exp_t e;
    e.frame = f;
    e.segs  = segs;
    e.en    = en;
    sb.push_back(e);
  endtask

  task automatic check_direct(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {SEG,AN,FRAME}=%b, expected %b", name, got, exp);
    end
  endtask

  task automatic wait_frame(output int f);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (FRAME !== 1'b1 && n < 4 * FL);
    checks++;
    if (FRAME !== 1'b1) begin
      errors++;
      $display("FAIL frame_timeout: got FRAME=%b after %0d cycles, expected 1", FRAME, n);
    end
    pos = 0;
    f   = frame_cnt;
  endtask

  task automatic goto(input int n);
    while (pos < n) begin
      @(negedge CLK);
      pos++;
    end
  endtask

  task automatic do_load(input int at, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] en, input logic blz);
    goto(at);
    D = d; DP = dp; EN = en; BLANK_LZ = blz;
    LOAD = 1'b1;
    @(negedge CLK);
    pos++;
    LOAD = 1'b0;
  endtask

  initial begin : stim
    int f;
    int n;

    // Reset release
    repeat (3) @(negedge CLK);
    check_direct("reset_outputs", {SEG, AN, FRAME}, {8'hFF, 4'hF, 1'b0});
    RST_N = 1'b1;
    @(negedge CLK);
    check_direct("frame_after_reset", {SEG, AN, FRAME}, {8'hFF, 4'hF, 1'b1});
    f   = frame_cnt;
    pos = 0;
    push(f, 32'h0, 4'h0);

    // Scan and decode; LOAD mid-frame keeps the current frame dark
    do_load(3, 16'h1A3F, 4'h0, 4'hF, 1'b0);
    push(f + 1, S_1A3F, 4'hF);

    // Leading-zero blanking
    wait_frame(f);
    do_load(10, 16'h0005, 4'h0, 4'hF, 1'b1);
    push(f + 1, S_LZ5, 4'hF);

    wait_frame(f);
    do_load(10, 16'h0005, 4'b0010, 4'hF, 1'b1);
    push(f + 1, S_LZDP, 4'hF);

    // Digit 2 disabled
    wait_frame(f);
    do_load(10, 16'h1A3F, 4'h0, 4'b1011, 1'b0);
    push(f + 1, S_1A3F, 4'b1011);

    // Two LOADs in one frame: last wins
    wait_frame(f);
    do_load(5, 16'h2468, 4'h0, 4'hF, 1'b0);
    do_load(20, 16'hBCDE, 4'b0101, 4'hF, 1'b0);
    push(f + 1, S_BCDE, 4'hF);

    // Pending load overridden by a LOAD on the boundary cycle
    wait_frame(f);
    do_load(10, 16'h0000, 4'h0, 4'hF, 1'b0);
    do_load(FL - 2, 16'h9604, 4'h0, 4'hF, 1'b0);
    push(f + 1, S_9604, 4'hF);
    push(f + 2, S_9604, 4'hF);
    wait_frame(f);
    wait_frame(f);

    // Reset mid-frame with a load pending
    do_load(10, 16'h1234, 4'h0, 4'hF, 1'b0);
    push(f + 1, S_1234, 4'hF);
    wait_frame(f);
    wait_frame(f);
    do_load(10, 16'h5678, 4'h0, 4'hF, 1'b0);
    goto(19);
    RST_N = 1'b0;
    @(negedge CLK);
    check_direct("reset_mid_frame_dark", {SEG, AN, FRAME}, {8'hFF, 4'hF, 1'b0});
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_direct("frame_after_mid_reset", {SEG, AN, FRAME}, {8'hFF, 4'hF, 1'b1});
    f   = frame_cnt;
    pos = 0;
    push(f, 32'h0, 4'h0);
    push(f + 1, 32'h0, 4'h0);

    // Drain scoreboard
    n = 0;
    while (sb.size() > 0 && n < 4 * FL) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d frames unchecked, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
